// File: rtl/snn_pkg.sv
// Shared constants and datapath helpers for the spiking-network nodes
// (spike_synapse and the lif neuron).
//
// Helpers operate on 32-bit containers so that any node width up to 31 bits
// can use them; callers cast arguments and results to their own width.
package snn_pkg;

   // Default datapath width for weights, currents and membrane potentials.
   localparam int unsigned SNN_WIDTH        = 8;
   // Default decay shift: each tick removes value >> SNN_DECAY_SHIFT.
   localparam int unsigned SNN_DECAY_SHIFT  = 2;
   // Default number of enabled clock cycles per decay tick.
   localparam int unsigned SNN_DECAY_PERIOD = 4;
   // Width of the observation event counter.
   localparam int unsigned SNN_COUNT_W      = 8;

   // One exponential-decay step: subtract value >> shift.
   // A nonzero value always loses at least 1, so it reaches 0 and never underflows.
   function automatic logic [31:0] decay_step(input logic [31:0] value,
                                              input int unsigned shift);
      logic [31:0] dec;
      dec = value >> shift;
      if ((value != 32'd0) && (dec == 32'd0)) begin
         dec = 32'd1;
      end
      return value - dec;
   endfunction

   // Unsigned add of two width-bit values, clipped at 2^width-1.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned width);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << width) - 33'd1;
      return (sum > lim) ? lim[31:0] : sum[31:0];
   endfunction

   // Carry-out of the width-bit add performed by sat_add.
   function automatic logic add_carry(input logic [31:0] a,
                                      input logic [31:0] b,
                                      input int unsigned width);
      logic [32:0] sum;
      logic [32:0] lim;
      sum = {1'b0, a} + {1'b0, b};
      lim = (33'd1 << width) - 33'd1;
      return (sum > lim);
   endfunction

endpackage

// File: rtl/decay_prescaler.sv
// Decay/leak prescaler: counts enabled cycles and raises tick_c on the last
// cycle of each PERIOD-cycle window.
//
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous reset, active-high; counter returns to 0
//   ena    - count enable; counter holds and tick_c is low when 0
//   tick_c - combinational tick, high when the counter sits at PERIOD-1 and ena=1
module decay_prescaler
   import snn_pkg::*;
#(
   parameter int unsigned PERIOD = SNN_DECAY_PERIOD   // must be >= 1
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   output logic tick_c
);

   localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);

   logic [PW-1:0] presc;

   // With PERIOD=1, LAST is 0 and the counter never leaves 0: tick every enabled cycle.
   assign tick_c = ena && (presc == LAST);

   // Counter wraps to 0 on the tick cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         presc <= '0;
      end else if (ena) begin
         presc <= tick_c ? '0 : presc + PW'(1);
      end
   end

endmodule

// File: rtl/spike_synapse.sv
// Synapse node: converts a spike train into a WIDTH-bit drive current.
// Each rising edge of spike_in adds weight (saturating); the current decays
// exponentially on each prescaler tick. Decay is applied before the add.
//
// Ports:
//   clk         - clock, rising edge
//   rst         - synchronous reset, active-high (overrides ena and count_clr)
//   ena         - update enable; edge history still tracks spike_in when low
//   spike_in    - upstream spike, same clock domain, may be multi-cycle
//   weight      - unsigned weight, sampled in the cycle an event is detected
//   count_clr   - synchronous clear of spike_count
//   current_out - registered synaptic current
//   spike_event - one-cycle pulse per accepted event
//   sat         - one-cycle pulse when an add clipped at max
//   spike_count - accepted events, wraps modulo 256
module spike_synapse
   import snn_pkg::*;
#(
   parameter int unsigned WIDTH        = SNN_WIDTH,
   parameter int unsigned DECAY_SHIFT  = SNN_DECAY_SHIFT,   // 1..WIDTH-1
   parameter int unsigned DECAY_PERIOD = SNN_DECAY_PERIOD   // >= 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   input  logic                   spike_in,
   input  logic [WIDTH-1:0]       weight,
   input  logic                   count_clr,
   output logic [WIDTH-1:0]       current_out,
   output logic                   spike_event,
   output logic                   sat,
   output logic [SNN_COUNT_W-1:0] spike_count
);

   logic                   spike_prev;
   logic                   tick_c;
   logic                   event_c;
   logic                   carry_c;
   logic [WIDTH-1:0]       decayed_c;
   logic [WIDTH-1:0]       next_current_c;
   logic [SNN_COUNT_W-1:0] next_count_c;

   // Decay timing.
   decay_prescaler #(
      .PERIOD (DECAY_PERIOD)
   ) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .tick_c (tick_c)
   );

   // Edge detect; an edge seen while disabled is consumed, not deferred.
   assign event_c = spike_in & ~spike_prev & ena;

   // Datapath: decay on tick, then saturating add on event.
   always_comb begin
      decayed_c      = current_out;
      next_current_c = current_out;
      carry_c        = 1'b0;
      if (tick_c) begin
         decayed_c = WIDTH'(decay_step(32'(current_out), DECAY_SHIFT));
      end
      next_current_c = decayed_c;
      if (event_c) begin
         next_current_c = WIDTH'(sat_add(32'(decayed_c), 32'(weight), WIDTH));
         carry_c        = add_carry(32'(decayed_c), 32'(weight), WIDTH);
      end
   end

   // Event counter: a clear coinciding with an event counts that event.
   always_comb begin
      next_count_c = spike_count;
      if (count_clr) begin
         next_count_c = event_c ? SNN_COUNT_W'(1) : '0;
      end else if (event_c) begin
         next_count_c = spike_count + SNN_COUNT_W'(1);
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         current_out <= '0;
         spike_prev  <= 1'b0;
         spike_count <= '0;
         spike_event <= 1'b0;
         sat         <= 1'b0;
      end else begin
         spike_prev  <= spike_in;
         spike_event <= event_c;
         sat         <= carry_c;
         spike_count <= next_count_c;
         if (ena) begin
            current_out <= next_current_c;
         end
      end
   end

endmodule

// File: tb/tb_spike_synapse.sv
// Directed bench for spike_synapse (WIDTH=8, DECAY_SHIFT=2, DECAY_PERIOD=4).
// Stimulus pushes expected event responses and timed current/count probes
// into queues; a monitor on the falling edge pops and compares them.
module tb_spike_synapse;

   logic       clk;
   logic       rst;
   logic       ena;
   logic       spike_in;
   logic [7:0] weight;
   logic       count_clr;
   logic [7:0] current_out;
   logic       spike_event;
   logic       sat;
   logic [7:0] spike_count;

   typedef struct {
      logic [7:0] cur;
      logic       sat;
      logic [7:0] cnt;
   } ev_t;

   typedef struct {
      int         cyc;
      logic [7:0] cur;
      logic [7:0] cnt;
      string      name;
   } probe_t;

   ev_t    ev_q[$];
   probe_t probe_q[$];
   int     cyc;
   int     checks;
   int     failures;
   int     ev_idx;

   spike_synapse #(
      .WIDTH        (8),
      .DECAY_SHIFT  (2),
      .DECAY_PERIOD (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .spike_in    (spike_in),
      .weight      (weight),
      .count_clr   (count_clr),
      .current_out (current_out),
      .spike_event (spike_event),
      .sat         (sat),
      .spike_count (spike_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare against queued expectations away from the active edge.
   initial begin
      checks   = 0;
      failures = 0;
      ev_idx   = 0;
      forever begin
         @(negedge clk);
         if (spike_event) begin
            checks++;
            if (ev_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_event cyc=%0d current=%0d count=%0d", cyc, current_out, spike_count);
            end else begin
               ev_t e;
               e = ev_q.pop_front();
               ev_idx++;
               if (current_out !== e.cur || sat !== e.sat || spike_count !== e.cnt) begin
                  failures++;
                  $display("FAIL event%0d got current=%0d sat=%0b count=%0d expected current=%0d sat=%0b count=%0d",
                           ev_idx, current_out, sat, spike_count, e.cur, e.sat, e.cnt);
               end
            end
         end else if (sat !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL stray_sat cyc=%0d got sat=%0b expected 0", cyc, sat);
         end
         while (probe_q.size() != 0 && probe_q[0].cyc == cyc) begin
            probe_t p;
            p = probe_q.pop_front();
            checks++;
            if (current_out !== p.cur || spike_count !== p.cnt) begin
               failures++;
               $display("FAIL %s got current=%0d count=%0d expected current=%0d count=%0d",
                        p.name, current_out, spike_count, p.cur, p.cnt);
            end
         end
      end
   end

   task automatic go(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_ev(input logic [7:0] cur, input logic s, input logic [7:0] cnt);
      ev_t e;
      e.cur = cur;
      e.sat = s;
      e.cnt = cnt;
      ev_q.push_back(e);
   endtask

   // Probe checked at the falling edge following the current point in time.
   task automatic expect_now(input string name, input logic [7:0] cur, input logic [7:0] cnt);
      probe_t p;
      p.cyc  = cyc;
      p.cur  = cur;
      p.cnt  = cnt;
      p.name = name;
      probe_q.push_back(p);
   endtask

   // Reset, then one disabled edge; the next edge sees presc=0.
   task automatic do_reset();
      rst = 1'b1; ena = 1'b1; spike_in = 1'b0; count_clr = 1'b0;
      go(1);
      rst = 1'b0; ena = 1'b0;
      go(1);
      ena = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset held 2 cycles with spike high: no event, state zero.
      rst = 1'b1; ena = 1'b1; spike_in = 1'b1; weight = 8'd50; count_clr = 1'b0;
      go(2);
      expect_now("reset", 8'd0, 8'd0);
      rst = 1'b0; ena = 1'b0; spike_in = 1'b0;
      go(1);
      ena = 1'b1;

      // Single spike at presc=0, then ticks at phases 3, 7, 11.
      spike_in = 1'b1; weight = 8'd100;
      push_ev(8'd100, 1'b0, 8'd1);
      go(1);
      spike_in = 1'b0;
      go(3);
      expect_now("decay_75", 8'd75, 8'd1);
      go(4);
      expect_now("decay_57", 8'd57, 8'd1);
      go(4);
      expect_now("decay_43", 8'd43, 8'd1);
      go(2);

      // Long pulse: one event only; 20 -> 15 -> 12 by phase 9.
      do_reset();
      spike_in = 1'b1; weight = 8'd20;
      push_ev(8'd20, 1'b0, 8'd1);
      go(10);
      expect_now("long_pulse", 8'd12, 8'd1);
      spike_in = 1'b0;
      go(2);

      // Saturation: 200, 255 (sat), tick to 192, 255 (sat).
      do_reset();
      spike_in = 1'b1; weight = 8'd200;
      push_ev(8'd200, 1'b0, 8'd1);
      go(1);
      spike_in = 1'b0;
      go(1);
      spike_in = 1'b1;
      push_ev(8'd255, 1'b1, 8'd2);
      go(1);
      spike_in = 1'b0;
      go(1);
      expect_now("sat_decay", 8'd192, 8'd2);
      spike_in = 1'b1;
      push_ev(8'd255, 1'b1, 8'd3);
      go(1);
      spike_in = 1'b0;
      go(1);

      // Small-value decay: 3 -> 2 -> 1 -> 0 -> 0.
      do_reset();
      spike_in = 1'b1; weight = 8'd3;
      push_ev(8'd3, 1'b0, 8'd1);
      go(1);
      spike_in = 1'b0;
      go(3);
      expect_now("small_2", 8'd2, 8'd1);
      go(4);
      expect_now("small_1", 8'd1, 8'd1);
      go(4);
      expect_now("small_0", 8'd0, 8'd1);
      go(4);
      expect_now("small_hold0", 8'd0, 8'd1);

      // Event on a tick edge: 100 decays to 75, then +10.
      do_reset();
      spike_in = 1'b1; weight = 8'd100;
      push_ev(8'd100, 1'b0, 8'd1);
      go(1);
      spike_in = 1'b0;
      go(2);
      spike_in = 1'b1; weight = 8'd10;
      push_ev(8'd85, 1'b0, 8'd2);
      go(1);
      spike_in = 1'b0;
      go(1);

      // count_clr with an event gives 1; count_clr alone gives 0.
      spike_in = 1'b1; count_clr = 1'b1;
      push_ev(8'd95, 1'b0, 8'd1);
      go(1);
      spike_in = 1'b0;
      go(1);
      expect_now("clr_only", 8'd95, 8'd0);
      count_clr = 1'b0;
      go(1);
      expect_now("pre_freeze", 8'd72, 8'd0);

      // ena=0 across a rising edge: dropped, current and presc frozen.
      ena = 1'b0;
      go(1);
      spike_in = 1'b1;
      go(2);
      expect_now("frozen", 8'd72, 8'd0);
      ena = 1'b1;
      go(1);
      spike_in = 1'b0;
      go(2);
      expect_now("post_freeze", 8'd72, 8'd0);
      go(1);
      expect_now("resume_tick", 8'd54, 8'd0);

      // Zero weight: counted and pulsed, current unchanged.
      spike_in = 1'b1; weight = 8'd0;
      push_ev(8'd54, 1'b0, 8'd1);
      go(1);
      spike_in = 1'b0;
      go(4);

      checks++;
      if (ev_q.size() != 0) begin
         failures++;
         $display("FAIL missing_events got pending=%0d expected 0", ev_q.size());
      end
      checks++;
      if (probe_q.size() != 0) begin
         failures++;
         $display("FAIL missing_probes got pending=%0d expected 0", probe_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
